seq_decoder: RTL and testbench

Parametrised, registered successor to the team's 3-to-8 enable decoder. It decodes an SEL_W-bit select into a 2**SEL_W-bit output vector and adds command handshaking and four output modes: one-hot hold, thermometer, timed pulse and rotating scan. It sits between control FSMs and downstream one-hot consumers such as LED/segment strobes and bank selects, and replaces the purely combinational decoder wherever registered, glitch-free selects are required.

---
 rtl/seq_decoder_pkg.sv | 25 ++
 rtl/onehot_therm_dec.sv | 25 ++
 rtl/seq_decoder.sv | 123 ++++++++++++
 tb/tb_seq_decoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_decoder_pkg.sv
// Shared types and helpers for the registered sequencing decoder.
//   mode_e  : command mode encoding carried on the 2-bit mode port
//   state_e : controller states of seq_decoder
//   out_w() : decoded output width for a given select width
package seq_decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERM  = 2'b01,
    MODE_PULSE  = 2'b10,
    MODE_SCAN   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_PULSE,
    ST_SCAN
  } state_e;

  function automatic int unsigned out_w(input int unsigned sel_w);
    return 32'd1 << sel_w;
  endfunction

endpackage

// File: rtl/onehot_therm_dec.sv
// Combinational select decoder producing both one-hot and thermometer codes.
//   sel    : select index (SEL_W bits)
//   onehot : bit sel set, all others clear
//   therm  : bits [sel:0] set, all others clear
module onehot_therm_dec
  import seq_decoder_pkg::*;
#(
  parameter int unsigned SEL_W = 3,
  localparam int unsigned OUT_W = out_w(SEL_W)
) (
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] onehot,
  output logic [OUT_W-1:0] therm
);

  always_comb begin
    onehot = '0;
    therm  = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      onehot[i] = (32'(sel) == i);
      therm[i]  = (i <= 32'(sel));
    end
  end

endmodule

// File: rtl/seq_decoder.sv
// Registered select decoder with command handshake and four output modes
// (one-hot hold, thermometer hold, timed pulse, rotating scan).
//   clk, rst  : clock, synchronous active-high reset
//   en        : global enable; low clears d and returns to idle
//   in_valid  : command present; in_ready : command can be accepted
//   sel, mode : command select index and output mode
//   d         : registered decoded output
//   d_strobe  : one-cycle pulse when d takes a new non-zero value
//   busy      : pulse or scan in progress
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned SCAN_DIV  = 8,
  localparam int unsigned OUT_W = out_w(SEL_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] d,
  output logic             d_strobe,
  output logic             busy
);

  localparam int unsigned CNT_MAX = (PULSE_LEN > SCAN_DIV) ? PULSE_LEN : SCAN_DIV;
  localparam int unsigned CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [OUT_W-1:0] d_nx;
  logic             strobe_nx;
  logic [OUT_W-1:0] onehot, therm;
  logic             accept;

  onehot_therm_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel    (sel),
    .onehot (onehot),
    .therm  (therm)
  );

  assign in_ready = en && (state != ST_PULSE);
  assign busy     = (state == ST_PULSE) || (state == ST_SCAN);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nx  = state;
    d_nx      = d;
    cnt_nx    = cnt;
    strobe_nx = 1'b0;
    if (!en) begin
      state_nx = ST_IDLE;
      d_nx     = '0;
      cnt_nx   = '0;
    end else if (accept) begin
      // An accepted command replaces hold/scan on the same edge.
      strobe_nx = 1'b1;
      cnt_nx    = '0;
      case (mode_e'(mode))
        MODE_ONEHOT: begin
          d_nx     = onehot;
          state_nx = ST_HOLD;
        end
        MODE_THERM: begin
          d_nx     = therm;
          state_nx = ST_HOLD;
        end
        MODE_PULSE: begin
          d_nx     = onehot;
          cnt_nx   = CNT_W'(PULSE_LEN - 1);
          state_nx = ST_PULSE;
        end
        MODE_SCAN: begin
          d_nx     = onehot;
          cnt_nx   = CNT_W'(SCAN_DIV - 1);
          state_nx = ST_SCAN;
        end
      endcase
    end else begin
      case (state)
        ST_PULSE: begin
          if (cnt == '0) begin
            d_nx     = '0;
            state_nx = ST_IDLE;
          end else begin
            cnt_nx = cnt - CNT_W'(1);
          end
        end
        ST_SCAN: begin
          if (cnt == '0) begin
            d_nx      = {d[OUT_W-2:0], d[OUT_W-1]};
            cnt_nx    = CNT_W'(SCAN_DIV - 1);
            strobe_nx = 1'b1;
          end else begin
            cnt_nx = cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      d        <= '0;
      d_strobe <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nx;
      d        <= d_nx;
      d_strobe <= strobe_nx;
      cnt      <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder (SEL_W=3, PULSE_LEN=4, SCAN_DIV=2).
// A cycle-level model tracks the last accepted command and the cycles since
// it was accepted; outputs are derived from that elapsed count.
module tb_seq_decoder;

  localparam int SEL_W     = 3;
  localparam int OUT_W     = 8;
  localparam int PULSE_LEN = 4;
  localparam int SCAN_DIV  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic [1:0]       mode;
  logic [OUT_W-1:0] d;
  logic             d_strobe;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_decoder #(
    .SEL_W     (SEL_W),
    .PULSE_LEN (PULSE_LEN),
    .SCAN_DIV  (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .mode     (mode),
    .d        (d),
    .d_strobe (d_strobe),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: kind 0 idle, 1 hold, 2 pulse, 3 scan
  int m_kind = 0;
  int m_sel = 0;
  int m_elapsed = 0;
  int m_hold = 0;
  bit started = 1'b0;

  function automatic bit m_pulse_busy();
    return (m_kind == 2) && (m_elapsed < PULSE_LEN);
  endfunction

  function automatic int m_d();
    case (m_kind)
      1: return m_hold;
      2: return m_pulse_busy() ? (1 << m_sel) : 0;
      3: return 1 << ((m_sel + m_elapsed / SCAN_DIV) % OUT_W);
      default: return 0;
    endcase
  endfunction

  function automatic int m_strobe();
    case (m_kind)
      1, 2: return (m_elapsed == 0) ? 1 : 0;
      3: return (m_elapsed % SCAN_DIV == 0) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int m_ready();
    return (en && !m_pulse_busy()) ? 1 : 0;
  endfunction

  function automatic int m_busy();
    return (m_pulse_busy() || m_kind == 3) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_kind  = 0;
      started = 1'b1;
    end else if (!en) begin
      m_kind = 0;
    end else if (in_valid && m_ready() == 1) begin
      m_sel     = int'(sel);
      m_elapsed = 0;
      case (mode)
        2'b00: begin m_kind = 1; m_hold = 1 << m_sel; end
        2'b01: begin m_kind = 1; m_hold = (1 << (m_sel + 1)) - 1; end
        2'b10: m_kind = 2;
        default: m_kind = 3;
      endcase
    end else begin
      m_elapsed++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_d", 32'(d), m_d());
      chk("model_strobe", 32'(d_strobe), m_strobe());
      chk("model_busy", 32'(busy), m_busy());
      chk("model_ready", 32'(in_ready), m_ready());
    end
  end

  task automatic drive(input logic e, input logic v, input logic [SEL_W-1:0] s, input logic [1:0] m);
    #1;
    en       = e;
    in_valid = v;
    sel      = s;
    mode     = m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] scan_d [7] = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01, 8'h02};

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; sel = 3'd5; mode = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_d", 32'(d), 32'h00);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobe", 32'(d_strobe), 0);
    chk("rst_ready", 32'(in_ready), 1);

    // One-hot then thermometer
    drive(1, 1, 3'd5, 2'b00);
    @(negedge clk);
    chk("onehot_d", 32'(d), 32'h20);
    chk("onehot_strobe", 32'(d_strobe), 1);
    drive(1, 1, 3'd2, 2'b01);
    @(negedge clk);
    chk("therm_d", 32'(d), 32'h07);
    chk("therm_strobe", 32'(d_strobe), 1);
    drive(1, 0, 3'd2, 2'b01);
    repeat (2) begin
      @(negedge clk);
      chk("therm_hold", 32'(d), 32'h07);
      chk("therm_hold_strobe", 32'(d_strobe), 0);
    end
    drive(1, 1, 3'd7, 2'b01);
    @(negedge clk);
    chk("therm_max", 32'(d), 32'hff);
    drive(1, 1, 3'd0, 2'b01);
    @(negedge clk);
    chk("therm_min", 32'(d), 32'h01);

    // Pulse with a stalled follow-up command
    drive(1, 1, 3'd7, 2'b10);
    @(negedge clk);
    chk("pulse_d1", 32'(d), 32'h80);
    chk("pulse_ready1", 32'(in_ready), 0);
    chk("pulse_busy", 32'(busy), 1);
    drive(1, 1, 3'd0, 2'b00);
    for (int i = 2; i <= PULSE_LEN; i++) begin
      @(negedge clk);
      chk("pulse_d", 32'(d), 32'h80);
      chk("pulse_ready", 32'(in_ready), 0);
    end
    @(negedge clk);
    chk("pulse_end_d", 32'(d), 32'h00);
    chk("pulse_end_strobe", 32'(d_strobe), 0);
    chk("pulse_end_ready", 32'(in_ready), 1);
    @(negedge clk);
    chk("stalled_cmd_d", 32'(d), 32'h01);
    chk("stalled_cmd_strobe", 32'(d_strobe), 1);

    // Scan with wrap
    drive(1, 1, 3'd6, 2'b11);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("scan_d", 32'(d), 32'(scan_d[k]));
      chk("scan_strobe", 32'(d_strobe), (k % 2 == 0) ? 1 : 0);
      if (k == 0) drive(1, 0, 3'd6, 2'b11);
    end

    // Abort scan, then disable with a command pending
    drive(1, 1, 3'd3, 2'b00);
    @(negedge clk);
    chk("abort_d", 32'(d), 32'h08);
    chk("abort_busy", 32'(busy), 0);
    drive(0, 1, 3'd1, 2'b00);
    @(negedge clk);
    chk("en_low_d", 32'(d), 32'h00);
    chk("en_low_ready", 32'(in_ready), 0);
    chk("en_low_strobe", 32'(d_strobe), 0);
    drive(1, 0, 3'd1, 2'b00);
    repeat (2) begin
      @(negedge clk);
      chk("en_restore_d", 32'(d), 32'h00);
      chk("en_restore_ready", 32'(in_ready), 1);
    end

    // Reset in the middle of a pulse
    drive(1, 1, 3'd4, 2'b10);
    @(negedge clk);
    chk("pulse2_d", 32'(d), 32'h10);
    drive(1, 0, 3'd4, 2'b10);
    @(negedge clk);
    chk("pulse2_d_cyc2", 32'(d), 32'h10);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_d", 32'(d), 32'h00);
    chk("midrst_busy", 32'(busy), 0);
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("postrst_d", 32'(d), 32'h00);
      chk("postrst_busy", 32'(busy), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
